// File: rtl/kernel_call_sequencer.sv
// rtl/kernel_call_sequencer.sv - runs a start/idle/valid kernel N times per command and queues each retval
// Launches are held back until the result FIFO has room, so every return value has a reserved slot.
module kernel_call_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   parameter int DEPTH  = 4
) (
   input  logic              __clk,
   input  logic              __reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              k_start,
   input  logic              k_idle,
   input  logic              k_valid,
   input  logic [DATA_W-1:0] k_retval,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_last,
   output logic              busy,
   output logic              spur_err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       occ_q, occ_d;
   logic [DATA_W:0]   mem_q [DEPTH];
   logic [DATA_W:0]   mem_d [DEPTH];
   logic              spur_q, spur_d;
   logic              push;
   logic              pop;

   assign k_start   = (state_q == S_LAUNCH) && k_idle && (occ_q < OCC_FULL);
   assign push      = (state_q == S_WAIT) && k_valid;
   assign res_valid = (occ_q != '0);
   assign pop       = res_valid && res_ready;
   assign res_data  = mem_q[rd_ptr_q][DATA_W-1:0];
   assign res_last  = mem_q[rd_ptr_q][DATA_W];
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign spur_err  = spur_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      spur_d  = spur_q | (k_valid && (state_q != S_WAIT));
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rem_d = cmd_count;
               if (cmd_count != '0) begin
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            if (k_start) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (k_valid) begin
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_q == CNT_W'(1)) ? S_IDLE : S_LAUNCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Show-ahead FIFO; the head entry carries the last-of-command flag in its top bit.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         mem_d[wr_ptr_q] = {(rem_q == CNT_W'(1)), k_retval};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge __clk) begin
      if (__reset) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         spur_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         spur_q   <= spur_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_kernel_call_sequencer.sv
// tb/tb_kernel_call_sequencer.sv - self-checking bench for kernel_call_sequencer
// A behavioural kernel answers each start; a queue of expected {last, retval} entries checks the stream.
module tb_kernel_call_sequencer;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int DEPTH  = 2;

   logic              __clk;
   logic              __reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CNT_W-1:0]  cmd_count;
   logic              k_start;
   logic              k_idle;
   logic              k_valid;
   logic [DATA_W-1:0] k_retval;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_last;
   logic              busy;
   logic              spur_err;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0]   exp_q [$];
   logic [DATA_W-1:0] rv_q [$];
   logic [DATA_W-1:0] new_rv [$];
   int  klat       = 4;
   int  rdy_mode   = 0;
   int  calls_left = 0;
   int  starts     = 0;
   int  reset_cnt  = 0;
   int  spur_req   = 0;
   int  spur_done  = 0;
   int  kst        = 0;
   bit  chk_b2b    = 0;

   kernel_call_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .__clk     (__clk),
      .__reset   (__reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_count (cmd_count),
      .k_start   (k_start),
      .k_idle    (k_idle),
      .k_valid   (k_valid),
      .k_retval  (k_retval),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_last  (res_last),
      .busy      (busy),
      .spur_err  (spur_err)
   );

   initial begin
      __clk = 1'b0;
      forever #5 __clk = ~__clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Consumer ready: 0 hold low, 1 hold high, 2 toggle every cycle, 3 random
   initial begin
      res_ready = 1'b0;
      forever begin
         @(negedge __clk);
         case (rdy_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            2:       res_ready = ~res_ready;
            default: res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Kernel model: 0 idle, 1 start taken, 2 computing, 3 valid pulse, 4 spurious pulse
   initial begin
      int cnt;
      int seen_reset;
      cnt        = 0;
      seen_reset = 0;
      k_idle     = 1'b1;
      k_valid    = 1'b0;
      k_retval   = '0;
      forever begin
         @(negedge __clk);
         if (seen_reset != reset_cnt) begin
            seen_reset = reset_cnt;
            kst        = 0;
            k_idle     = 1'b1;
            k_valid    = 1'b0;
         end else begin
            case (kst)
               1: begin
                  k_idle = 1'b0;
                  cnt    = klat;
                  kst    = 2;
               end
               2: begin
                  if (cnt > 1) begin
                     cnt--;
                  end else begin
                     k_valid = 1'b1;
                     k_idle  = 1'b1;
                     if (rv_q.size() > 0) k_retval = rv_q.pop_front();
                     else                 k_retval = $urandom;
                     kst = 3;
                  end
               end
               3: begin
                  k_valid = 1'b0;
                  calls_left--;
                  checks++;
                  if (busy !== (calls_left != 0)) begin
                     errors++;
                     $display("FAIL busy_after_kvalid got=%b exp=%b", busy, (calls_left != 0));
                  end
                  checks++;
                  if (cmd_ready !== (calls_left == 0)) begin
                     errors++;
                     $display("FAIL cmd_ready_after_kvalid got=%b exp=%b", cmd_ready, (calls_left == 0));
                  end
                  checks++;
                  if (res_valid !== 1'b1) begin
                     errors++;
                     $display("FAIL res_valid_after_push got=%b exp=1", res_valid);
                  end
                  if (chk_b2b && calls_left > 0) begin
                     checks++;
                     if (k_start !== 1'b1) begin
                        errors++;
                        $display("FAIL back_to_back_start got=%b exp=1", k_start);
                     end
                  end
                  kst = 0;
               end
               4: begin
                  k_valid = 1'b0;
                  spur_done++;
                  kst = 0;
               end
               default: ;
            endcase
            if (kst == 0) begin
               if (k_start === 1'b1) begin
                  kst = 1;
                  starts++;
               end else if (spur_req != spur_done) begin
                  k_valid  = 1'b1;
                  k_retval = $urandom;
                  kst      = 4;
               end
            end
         end
      end
   end

   // Scoreboard: every accepted result must be the next expected {last, retval}
   initial begin
      logic [DATA_W:0] e;
      forever begin
         @(negedge __clk);
         #1;
         if (__reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result got=%b/%h exp=none", res_last, res_data);
            end else begin
               e = exp_q.pop_front();
               if ({res_last, res_data} !== e) begin
                  errors++;
                  $display("FAIL result_stream got=%b/%h exp=%b/%h", res_last, res_data, e[DATA_W], e[DATA_W-1:0]);
               end
            end
         end
      end
   end

   task automatic apply_reset();
      rdy_mode = 0;
      repeat (2) @(negedge __clk);
      __reset   = 1'b1;
      cmd_valid = 1'b0;
      reset_cnt++;
      exp_q.delete();
      rv_q.delete();
      calls_left = 0;
      @(negedge __clk);
      __reset = 1'b0;
   endtask

   task automatic run_cmd(input int n);
      int t;
      logic [DATA_W-1:0] v;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 3000) begin
         @(negedge __clk);
         t++;
      end
      checks++;
      if (t >= 3000) begin
         errors++;
         $display("FAIL cmd_ready_timeout got=%b exp=1", cmd_ready);
      end
      for (int i = 0; i < n; i++) begin
         if (i < new_rv.size()) v = new_rv[i];
         else                   v = $urandom;
         rv_q.push_back(v);
         exp_q.push_back({(i == n - 1), v});
      end
      new_rv.delete();
      calls_left = n;
      cmd_valid  = 1'b1;
      cmd_count  = CNT_W'(n);
      @(negedge __clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0 || kst != 0) && t < 3000) begin
         @(negedge __clk);
         t++;
      end
      checks++;
      if (t >= 3000) begin
         errors++;
         $display("FAIL drain_timeout busy=%b pending=%0d exp=0", busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (k_start !== 1'b0)   begin errors++; $display("FAIL reset_k_start got=%b exp=0", k_start); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_data !== '0)    begin errors++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
      checks++; if (res_last !== 1'b0)  begin errors++; $display("FAIL reset_res_last got=%b exp=0", res_last); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (spur_err !== 1'b0)  begin errors++; $display("FAIL reset_spur_err got=%b exp=0", spur_err); end
   endtask

   task automatic test_single_cmd();
      int s0;
      rdy_mode = 1;
      klat     = 12;
      chk_b2b  = 1;
      s0       = starts;
      for (int i = 0; i < 3; i++) new_rv.push_back(32'd3);
      run_cmd(3);
      wait_done();
      chk_b2b = 0;
      checks++;
      if (starts - s0 != 3) begin
         errors++;
         $display("FAIL single_cmd_starts got=%0d exp=3", starts - s0);
      end
   endtask

   task automatic test_backpressure();
      int s0;
      int t;
      rdy_mode = 0;
      klat     = 2;
      s0       = starts;
      run_cmd(4);
      repeat (30) @(negedge __clk);
      checks++; if (starts - s0 != 2) begin errors++; $display("FAIL full_starts got=%0d exp=2", starts - s0); end
      checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
      checks++; if (k_start !== 1'b0) begin errors++; $display("FAIL full_k_start got=%b exp=0", k_start); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL full_res_valid got=%b exp=1", res_valid); end
      spur_req++;
      t = 0;
      while (spur_done != spur_req && t < 20) begin
         @(negedge __clk);
         t++;
      end
      @(negedge __clk);
      checks++; if (spur_err !== 1'b1) begin errors++; $display("FAIL launch_spur_err got=%b exp=1", spur_err); end
      rdy_mode = 1;
      wait_done();
      checks++; if (starts - s0 != 4) begin errors++; $display("FAIL drained_starts got=%0d exp=4", starts - s0); end
      apply_reset();
   endtask

   task automatic test_zero_count();
      int s0;
      int bad;
      rdy_mode = 1;
      s0       = starts;
      bad      = 0;
      run_cmd(0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (busy !== 1'b0 || cmd_ready !== 1'b1 || k_start !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_idle busy=%b cmd_ready=%b k_start=%b res_valid=%b exp=0/1/0/0",
                     busy, cmd_ready, k_start, res_valid);
         end
         @(negedge __clk);
      end
      checks++; if (starts != s0) begin errors++; $display("FAIL zero_count_starts got=%0d exp=%0d", starts, s0); end
   endtask

   task automatic test_spurious();
      int t;
      rdy_mode = 1;
      spur_req++;
      t = 0;
      while (spur_done != spur_req && t < 20) begin
         @(negedge __clk);
         t++;
      end
      @(negedge __clk);
      checks++; if (spur_err !== 1'b1)  begin errors++; $display("FAIL idle_spur_err got=%b exp=1", spur_err); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL idle_spur_push got=%b exp=0", res_valid); end
      repeat (5) @(negedge __clk);
      checks++; if (spur_err !== 1'b1)  begin errors++; $display("FAIL spur_err_sticky got=%b exp=1", spur_err); end
      apply_reset();
      checks++; if (spur_err !== 1'b0)  begin errors++; $display("FAIL spur_err_reset got=%b exp=0", spur_err); end
   endtask

   task automatic test_reset_midflight();
      int s0;
      int t;
      rdy_mode = 1;
      klat     = 10;
      s0       = starts;
      run_cmd(5);
      t = 0;
      while (starts - s0 < 2 && t < 200) begin
         @(negedge __clk);
         t++;
      end
      checks++; if (t >= 200) begin errors++; $display("FAIL midflight_second_start got=%0d exp=2", starts - s0); end
      repeat (3) @(negedge __clk);
      apply_reset();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midreset_res_valid got=%b exp=0", res_valid); end
      checks++; if (k_start !== 1'b0)   begin errors++; $display("FAIL midreset_k_start got=%b exp=0", k_start); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_cmd_ready got=%b exp=1", cmd_ready); end
      rdy_mode = 1;
      klat     = 3;
      run_cmd(1);
      wait_done();
   endtask

   task automatic test_concurrent();
      rdy_mode = 2;
      klat     = 1;
      for (int i = 0; i < 8; i++) new_rv.push_back(DATA_W'(i));
      run_cmd(8);
      wait_done();
   endtask

   task automatic test_random();
      rdy_mode = 3;
      for (int c = 0; c < 8; c++) begin
         klat = $urandom_range(1, 6);
         run_cmd($urandom_range(1, 5));
      end
      wait_done();
   endtask

   initial begin
      __reset   = 1'b1;
      cmd_valid = 1'b0;
      cmd_count = '0;
      test_reset();
      test_single_cmd();
      test_backpressure();
      test_zero_count();
      test_spurious();
      test_reset_midflight();
      test_concurrent();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_results got=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
